// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : instr_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer.
// Revision : 1.0
// ============================================================================
module instr_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_load,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             reg_we,
    output logic             mem_we,
    output logic [2:0]       state,
    output logic             busy,
    output logic             ill_op,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    localparam logic [3:0] c_op_load = 4'b1000;
    localparam logic [3:0] c_op_bez  = 4'b1100;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_op;
    logic             r_ill;
    logic [CNT_W-1:0] r_cnt;
    logic             w_retire;

    function automatic logic is_alu(input logic [3:0] op);
        return (op >= 4'b0001) && (op <= 4'b0101);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == 4'b1001) || (op == 4'b1010);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op == 4'b0000) || is_alu(op) || (op == c_op_load) ||
               is_store(op) || (op == c_op_bez);
    endfunction

    // Next-state and retire decode; DECODE looks at the live opcode, later
    // phases use the captured copy so the IR field may change freely.
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (imem_ack) w_next = S_DECODE;
            S_DECODE: begin
                if (is_legal(opcode) && (opcode != 4'b0000)) w_next = S_EXEC;
                else                                         w_retire = 1'b1;
            end
            S_EXEC: begin
                if (r_op == c_op_bez)  w_retire = 1'b1;
                else if (is_alu(r_op)) w_next = S_WB;
                else                   w_next = S_MEM;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (r_op == c_op_load) w_next = S_WB;
                    else                   w_retire = 1'b1;
                end
            end
            S_WB:     w_retire = 1'b1;
            default:  w_next = S_IDLE;
        endcase
        if (w_retire) w_next = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= 4'b0000;
            r_ill   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= opcode;
                if (!is_legal(opcode)) r_ill <= 1'b1;
            end
            if (w_retire) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign imem_req  = (r_state == S_FETCH);
    assign dmem_req  = (r_state == S_MEM);
    assign ir_load   = (r_state == S_FETCH) && imem_ack;
    assign pc_en     = w_retire;
    assign pc_sel    = (r_state == S_EXEC) && (r_op == c_op_bez) && zero;
    assign reg_we    = (r_state == S_WB);
    assign mem_we    = (r_state == S_MEM) && is_store(r_op);
    assign state     = r_state;
    assign busy      = (r_state != S_IDLE);
    assign ill_op    = r_ill;
    assign instr_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_sequencer
// Brief    : Self-checking bench; instruction-level model builds the expected
//            per-cycle waveform of each instruction from its phase list.
// Revision : 1.0
// ============================================================================
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, run, zero, imem_ack, dmem_ack;
    logic [3:0]  opcode;
    logic        imem_req, dmem_req, ir_load, pc_en, pc_sel, reg_we, mem_we, busy, ill_op;
    logic [2:0]  state;
    logic [15:0] instr_cnt;
    logic        imem_req_b, dmem_req_b, ir_load_b, pc_en_b, pc_sel_b, reg_we_b, mem_we_b;
    logic        busy_b, ill_op_b;
    logic [2:0]  state_b;
    logic [3:0]  instr_cnt_b;

    instr_sequencer #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req),
        .dmem_req(dmem_req), .ir_load(ir_load), .pc_en(pc_en), .pc_sel(pc_sel),
        .reg_we(reg_we), .mem_we(mem_we), .state(state), .busy(busy),
        .ill_op(ill_op), .instr_cnt(instr_cnt)
    );

    // Narrow counter copy makes the all-ones wrap reachable quickly.
    instr_sequencer #(.CNT_W(4)) u_dut_w4 (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack), .imem_req(imem_req_b),
        .dmem_req(dmem_req_b), .ir_load(ir_load_b), .pc_en(pc_en_b), .pc_sel(pc_sel_b),
        .reg_we(reg_we_b), .mem_we(mem_we_b), .state(state_b), .busy(busy_b),
        .ill_op(ill_op_b), .instr_cnt(instr_cnt_b)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] m_cnt;
    logic        m_ill;
    logic        m_idle;
    int          g_lat_cnt, g_lat;
    logic        g_seen, g_psel;

    typedef struct {
        logic [3:0] op;
        int         fw;
        int         mw;
        logic       z;
        logic       run_after;
        int         exp_lat;
        logic       exp_psel;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Called with inputs already driven (just after a negedge); compares,
    // then advances across one rising edge.
    task automatic cyc(input string nm, input logic [2:0] st, input logic ir,
                       input logic pe, input logic ps, input logic rw,
                       input logic mw, input logic set_ill);
        logic [11:0] exp_v, act_v;
        #1;
        exp_v = {st, st != 3'd0, st == 3'd1, st == 3'd4, ir, pe, ps, rw, mw, m_ill};
        act_v = {state, busy, imem_req, dmem_req, ir_load, pc_en, pc_sel, reg_we, mem_we, ill_op};
        chk({nm, "_outputs"}, {20'd0, act_v}, {20'd0, exp_v});
        chk({nm, "_cnt"}, {16'd0, instr_cnt}, {16'd0, m_cnt});
        chk({nm, "_cnt_w4"}, {28'd0, instr_cnt_b}, {28'd0, m_cnt[3:0]});
        g_lat_cnt++;
        if (pc_en && !g_seen) begin
            g_seen = 1'b1;
            g_lat  = g_lat_cnt;
            g_psel = pc_sel;
        end
        if (pe) m_cnt = m_cnt + 16'd1;
        if (set_ill) m_ill = 1'b1;
        @(negedge clk);
    endtask

    task automatic noise();
        opcode = 4'($urandom);
        zero   = 1'($urandom);
    endtask

    task automatic idle_then_start(input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'b0; imem_ack = 1'($urandom); dmem_ack = 1'($urandom); noise();
            cyc("idle", 3'd0, 0, 0, 0, 0, 0, 0);
        end
        run = 1'b1; imem_ack = 1'($urandom); dmem_ack = 1'($urandom); noise();
        cyc("idle_go", 3'd0, 0, 0, 0, 0, 0, 0);
        m_idle = 1'b0;
    endtask

    // 0 = NOP/illegal, 1 = ALU, 2 = LOAD, 3 = STORE, 4 = BEZ
    function automatic int op_class(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return 1;
            4'd8:                         return 2;
            4'd9, 4'd10:                  return 3;
            4'd12:                        return 4;
            default:                      return 0;
        endcase
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return (op_class(op) == 0) && (op != 4'd0);
    endfunction

    task automatic run_instr(input logic [3:0] op, input int fw, input int mw,
                             input logic z, input logic run_after, output int lat);
        int c;
        c = op_class(op);
        if (m_idle) idle_then_start(int'($urandom_range(0, 2)));
        g_lat_cnt = 0; g_lat = 0; g_seen = 1'b0; g_psel = 1'b0;
        for (int i = 0; i < fw; i++) begin
            imem_ack = 1'b0; dmem_ack = 1'($urandom); run = 1'($urandom); noise();
            cyc("fetch_wait", 3'd1, 0, 0, 0, 0, 0, 0);
        end
        imem_ack = 1'b1; dmem_ack = 1'($urandom); run = 1'($urandom); noise();
        cyc("fetch_ack", 3'd1, 1, 0, 0, 0, 0, 0);
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom); zero = 1'($urandom);
        opcode = op;
        run = (c == 0) ? run_after : 1'($urandom);
        cyc("decode", 3'd2, 0, c == 0, 0, 0, 0, op_illegal(op));
        if (c != 0) begin
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom); noise();
            if (c == 4) zero = z;
            run = (c == 4) ? run_after : 1'($urandom);
            cyc("exec", 3'd3, 0, c == 4, (c == 4) && z, 0, 0, 0);
        end
        if (c == 2 || c == 3) begin
            for (int i = 0; i < mw; i++) begin
                dmem_ack = 1'b0; imem_ack = 1'($urandom); run = 1'($urandom); noise();
                cyc("mem_wait", 3'd4, 0, 0, 0, 0, c == 3, 0);
            end
            dmem_ack = 1'b1; imem_ack = 1'($urandom); noise();
            run = (c == 3) ? run_after : 1'($urandom);
            cyc("mem_ack", 3'd4, 0, c == 3, 0, 0, c == 3, 0);
        end
        if (c == 1 || c == 2) begin
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom); noise();
            run = run_after;
            cyc("wb", 3'd5, 0, 1, 0, 1, 0, 0);
        end
        m_idle = !run_after;
        lat = g_lat;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1; noise();
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0;
        m_cnt = 16'd0; m_ill = 1'b0; m_idle = 1'b1;
        cyc("after_reset", 3'd0, 0, 0, 0, 0, 0, 0);
    endtask

    vec_t vecs[15];

    initial begin
        int lat;
        logic [3:0] rop;
        vecs[0]  = '{4'b0001, 0, 0, 1'b0, 1'b1, 4, 1'b0};
        vecs[1]  = '{4'b0101, 0, 0, 1'b0, 1'b1, 4, 1'b0};
        vecs[2]  = '{4'b0000, 0, 0, 1'b0, 1'b1, 2, 1'b0};
        vecs[3]  = '{4'b1100, 0, 0, 1'b1, 1'b1, 3, 1'b1};
        vecs[4]  = '{4'b1100, 0, 0, 1'b0, 1'b1, 3, 1'b0};
        vecs[5]  = '{4'b1001, 0, 0, 1'b0, 1'b1, 4, 1'b0};
        vecs[6]  = '{4'b1010, 2, 1, 1'b0, 1'b0, 7, 1'b0};
        vecs[7]  = '{4'b1000, 0, 0, 1'b0, 1'b1, 5, 1'b0};
        vecs[8]  = '{4'b1000, 0, 3, 1'b0, 1'b1, 8, 1'b0};
        vecs[9]  = '{4'b0111, 0, 0, 1'b0, 1'b1, 2, 1'b0};
        vecs[10] = '{4'b0011, 1, 0, 1'b0, 1'b0, 5, 1'b0};
        vecs[11] = '{4'b1111, 0, 0, 1'b1, 1'b1, 2, 1'b0};
        vecs[12] = '{4'b0110, 0, 0, 1'b0, 1'b1, 2, 1'b0};
        vecs[13] = '{4'b1011, 1, 0, 1'b0, 1'b1, 3, 1'b0};
        vecs[14] = '{4'b1100, 0, 0, 1'b1, 1'b0, 3, 1'b1};

        rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        opcode = 4'd0; zero = 1'b0;
        m_cnt = 16'd0; m_ill = 1'b0; m_idle = 1'b1;
        @(negedge clk);
        do_reset();

        // Back-to-back ALU with zero-wait acks: three retirements.
        for (int i = 0; i < 3; i++) begin
            run_instr(4'b0001, 0, 0, 1'b0, 1'b1, lat);
            chk("alu_b2b_latency", lat, 4);
        end
        chk("alu_b2b_count", {16'd0, instr_cnt}, 32'd3);

        for (int i = 0; i < 15; i++) begin
            run_instr(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].z, vecs[i].run_after, lat);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d_pc_sel", i), {31'd0, g_psel}, {31'd0, vecs[i].exp_psel});
        end
        chk("ill_sticky", {31'd0, ill_op}, 32'd1);

        // Reset in MEM of a store with the ack arriving that same cycle.
        do_reset();
        chk("ill_cleared", {31'd0, ill_op}, 32'd0);
        idle_then_start(0);
        imem_ack = 1'b1; run = 1'b1;
        cyc("rm_fetch", 3'd1, 1, 0, 0, 0, 0, 0);
        opcode = 4'b1001;
        cyc("rm_decode", 3'd2, 0, 0, 0, 0, 0, 0);
        cyc("rm_exec", 3'd3, 0, 0, 0, 0, 0, 0);
        dmem_ack = 1'b1; rst_n = 1'b0;
        #1;
        chk("rm_mem_we_pre", {31'd0, mem_we}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1; run = 1'b0; dmem_ack = 1'b1; imem_ack = 1'b1;
        m_idle = 1'b1;
        cyc("rm_post0", 3'd0, 0, 0, 0, 0, 0, 0);
        cyc("rm_post1", 3'd0, 0, 0, 0, 0, 0, 0);

        // Sixteen NOPs: the 4-bit counter passes all-ones back to zero.
        for (int i = 0; i < 16; i++) run_instr(4'b0000, 0, 0, 1'b0, 1'b1, lat);
        chk("wrap_w4", {28'd0, instr_cnt_b}, 32'd0);
        chk("wrap_w16", {16'd0, instr_cnt}, 32'd16);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0:       rop = 4'($urandom_range(1, 5));
                1:       rop = 4'd8;
                2:       rop = 4'($urandom_range(9, 10));
                3:       rop = 4'd12;
                default: rop = 4'($urandom);
            endcase
            run_instr(rop, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom), ($urandom_range(0, 9) < 7), lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
